// File: rtl/requant_relu_stage_pkg.sv
// Shared widths, activation limits and the round/ReLU/saturate helper
// used by requant_relu_stage.
package requant_relu_stage_pkg;

   localparam int ACC_W = 32;
   localparam int ACT_W = 8;
   localparam int SUM_W = ACC_W + 1;

   localparam logic signed [ACT_W-1:0] ACT_MIN = -8'sd128;
   localparam logic signed [ACT_W-1:0] ACT_MAX = 8'sd127;

   // Round half up, arithmetic shift, optional ReLU, then clamp to the int8 range.
   // One extra bit of headroom keeps the rounding add from wrapping.
   function automatic logic signed [ACT_W-1:0] requant(
      input logic signed [SUM_W-1:0] sum,
      input int                      shift,
      input logic                    relu
   );
      logic signed [SUM_W:0] ext;
      logic signed [SUM_W:0] one;
      logic signed [SUM_W:0] shifted;
      logic signed [SUM_W:0] hi;
      logic signed [SUM_W:0] lo;
      ext     = (SUM_W+1)'(sum);
      one     = (SUM_W+1)'(1);
      hi      = (SUM_W+1)'(ACT_MAX);
      lo      = (SUM_W+1)'(ACT_MIN);
      shifted = (ext + (one <<< (shift - 1))) >>> shift;
      if (relu && shifted[SUM_W]) begin
         shifted = '0;
      end
      if (shifted > hi) begin
         return ACT_MAX;
      end else if (shifted < lo) begin
         return ACT_MIN;
      end
      return shifted[ACT_W-1:0];
   endfunction

endpackage

// File: rtl/requant_relu_stage_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, one extra pointer bit for full/empty.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign rdata = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance; clear empties the FIFO without touching storage.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (wr_en && !clr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/requant_relu_stage.sv
// Bias add, requantize, ReLU and saturate accumulator results into int8
// activations tagged with their neuron index, buffered in an output FIFO.
// Optional running argmax per layer is built when REQUANT_ARGMAX_EN is defined.
module requant_relu_stage
   import requant_relu_stage_pkg::*;
#(
   parameter int NUM_NEURONS = 10,
   parameter int SHIFT       = 7,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            acc_valid,
   input  logic signed [ACC_W-1:0]         acc_data,
   input  logic signed [ACC_W-1:0]         bias,
   input  logic                            relu_en,
   input  logic                            clr,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic signed [ACT_W-1:0]         out_data,
   output logic [$clog2(NUM_NEURONS)-1:0]  out_idx,
   output logic                            out_last,
`ifdef REQUANT_ARGMAX_EN
   output logic                            argmax_valid,
   output logic [$clog2(NUM_NEURONS)-1:0]  argmax_idx,
`endif
   output logic                            overflow
);

   localparam int IDX_W = $clog2(NUM_NEURONS);
   localparam int FW    = ACT_W + IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   logic                    s1_valid_q, s1_valid_d;
   logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;
   logic                    s1_relu_q, s1_relu_d;
   logic [IDX_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;
   logic [FW-1:0]           hold_q, hold_d;

   logic signed [ACT_W-1:0] s2_act;
   logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [FW-1:0]           fifo_rdata;
   logic [FW-1:0]           head;

   assign s2_act    = requant(s1_sum_q, SHIFT, s1_relu_q);
   assign fifo_push = s1_valid_q && !clr;
   assign fifo_pop  = !fifo_empty && out_ready;

   sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({s2_act, cnt_q}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // When empty, the outputs show the last word that was popped.
   assign head      = fifo_empty ? hold_q : fifo_rdata;
   assign out_valid = !fifo_empty;
   assign out_data  = head[FW-1:IDX_W];
   assign out_idx   = head[IDX_W-1:0];
   assign out_last  = (out_idx == LAST_IDX);
   assign overflow  = ovf_q;

   // Stage 1 capture, neuron counter, sticky overflow and output hold value.
   always_comb begin
      s1_valid_d = acc_valid && !clr;
      s1_sum_d   = s1_sum_q;
      s1_relu_d  = s1_relu_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      hold_d     = hold_q;
      if (acc_valid) begin
         s1_sum_d  = SUM_W'(acc_data) + SUM_W'(bias);
         s1_relu_d = relu_en;
      end
      if (fifo_pop) begin
         hold_d = fifo_rdata;
      end
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (s1_valid_q) begin
         cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
         if (fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
         end
      end
   end

   // Pipeline and control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s1_relu_q  <= 1'b0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         hold_q     <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sum_q   <= s1_sum_d;
         s1_relu_q  <= s1_relu_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         hold_q     <= hold_d;
      end
   end

`ifdef REQUANT_ARGMAX_EN
   logic signed [ACT_W-1:0] max_val_q, max_val_d;
   logic [IDX_W-1:0]        max_idx_q, max_idx_d;
   logic                    am_valid_q, am_valid_d;
   logic [IDX_W-1:0]        am_idx_q, am_idx_d;
   logic                    take;

   assign take         = s2_act > max_val_q;
   assign argmax_valid = am_valid_q;
   assign argmax_idx   = am_idx_q;

   // Running max over stage-2 results, including words the FIFO drops.
   always_comb begin
      max_val_d  = max_val_q;
      max_idx_d  = max_idx_q;
      am_valid_d = 1'b0;
      am_idx_d   = am_idx_q;
      if (clr) begin
         max_val_d = ACT_MIN;
         max_idx_d = '0;
         am_idx_d  = '0;
      end else if (s1_valid_q) begin
         if (cnt_q == LAST_IDX) begin
            am_valid_d = 1'b1;
            am_idx_d   = take ? cnt_q : max_idx_q;
            max_val_d  = ACT_MIN;
            max_idx_d  = '0;
         end else if (take) begin
            max_val_d = s2_act;
            max_idx_d = cnt_q;
         end
      end
   end

   // Argmax registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_val_q  <= ACT_MIN;
         max_idx_q  <= '0;
         am_valid_q <= 1'b0;
         am_idx_q   <= '0;
      end else begin
         max_val_q  <= max_val_d;
         max_idx_q  <= max_idx_d;
         am_valid_q <= am_valid_d;
         am_idx_q   <= am_idx_d;
      end
   end
`endif

endmodule

// File: tb/tb_requant_relu_stage.sv
// Self-checking bench for requant_relu_stage with a scoreboard queue of
// expected output words.
module tb_requant_relu_stage;

   localparam int NUM_NEURONS = 10;
   localparam int SHIFT       = 7;
   localparam int FIFO_DEPTH  = 4;
   localparam int IDX_W       = $clog2(NUM_NEURONS);

   typedef struct packed {
      logic signed [7:0] data;
      logic [IDX_W-1:0]  idx;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    acc_valid;
   logic signed [31:0]      acc_data;
   logic signed [31:0]      bias;
   logic                    relu_en;
   logic                    clr;
   logic                    out_ready;
   logic                    out_valid;
   logic signed [7:0]       out_data;
   logic [IDX_W-1:0]        out_idx;
   logic                    out_last;
   logic                    overflow;
`ifdef REQUANT_ARGMAX_EN
   logic                    argmax_valid;
   logic [IDX_W-1:0]        argmax_idx;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   int   exp_cnt = 0;
   int   occ = 0;

   always #5 clk = ~clk;

   requant_relu_stage #(
      .NUM_NEURONS (NUM_NEURONS),
      .SHIFT       (SHIFT),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .acc_valid    (acc_valid),
      .acc_data     (acc_data),
      .bias         (bias),
      .relu_en      (relu_en),
      .clr          (clr),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_idx      (out_idx),
      .out_last     (out_last),
`ifdef REQUANT_ARGMAX_EN
      .argmax_valid (argmax_valid),
      .argmax_idx   (argmax_idx),
`endif
      .overflow     (overflow)
   );

   function automatic logic signed [7:0] model(input longint a, input longint b, input bit relu);
      longint t;
      logic [63:0] r;
      t = (a + b + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      if (relu && t < 0) t = 0;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      r = 64'(t);
      return r[7:0];
   endfunction

   // One cycle at a negedge: score the head word if it pops on the next edge.
   task automatic step();
      exp_t e;
      if (out_valid && out_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: got data=%0d idx=%0d, expected no word", out_data, out_idx);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_idx !== e.idx ||
                out_last !== (e.idx == IDX_W'(NUM_NEURONS - 1))) begin
               n_errors++;
               $display("FAIL sb_word: got data=%0d idx=%0d last=%0b, expected data=%0d idx=%0d",
                        out_data, out_idx, out_last, e.data, e.idx);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic send(input int a, input int b, input bit relu);
      exp_t e;
      acc_valid = 1'b1;
      acc_data  = a;
      bias      = b;
      relu_en   = relu;
      e.data    = model(a, b, relu);
      e.idx     = IDX_W'(exp_cnt);
      if (out_ready) begin
         exp_q.push_back(e);
      end else if (occ < FIFO_DEPTH) begin
         exp_q.push_back(e);
         occ++;
      end
      exp_cnt = (exp_cnt == NUM_NEURONS - 1) ? 0 : exp_cnt + 1;
      step();
      acc_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         step();
         n++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain_timeout: %0d words still expected, wanted 0", exp_q.size());
         exp_q.delete();
      end
      occ = 0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_cnt = 0;
      occ = 0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'sd0 || out_idx !== '0 ||
          out_last !== 1'b0 || overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: got valid=%0b data=%0d idx=%0d last=%0b ovf=%0b, expected all 0",
                  out_valid, out_data, out_idx, out_last, overflow);
      end
`ifdef REQUANT_ARGMAX_EN
      n_checks++;
      if (argmax_valid !== 1'b0 || argmax_idx !== '0) begin
         n_errors++;
         $display("FAIL reset_argmax: got valid=%0b idx=%0d, expected 0 0", argmax_valid, argmax_idx);
      end
`endif
   endtask

   task automatic test_latency();
      do_clr();
      out_ready = 1'b0;
      send(1000, 24, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL latency_early: got out_valid=%0b after 1 cycle, expected 0", out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'sd8 || out_idx !== '0) begin
         n_errors++;
         $display("FAIL latency_word: got valid=%0b data=%0d idx=%0d, expected 1 8 0",
                  out_valid, out_data, out_idx);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'sd8) begin
         n_errors++;
         $display("FAIL hold_stall: got valid=%0b data=%0d, expected 1 8", out_valid, out_data);
      end
      drain();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'sd8 || out_idx !== '0) begin
         n_errors++;
         $display("FAIL hold_empty: got valid=%0b data=%0d idx=%0d, expected 0 8 0",
                  out_valid, out_data, out_idx);
      end
   endtask

   task automatic test_rounding();
      do_clr();
      out_ready = 1'b1;
      send(-300, 0, 1'b0);
      send(-300, 0, 1'b1);
      send(100000, 0, 1'b0);
      send(-100000, 0, 1'b0);
      send(-100000, 0, 1'b1);
      send(63, 0, 1'b0);
      send(64, 0, 1'b0);
      send(-65, 0, 1'b0);
      drain();
      n_checks++;
      if (model(-300, 0, 1'b0) !== -8'sd2 || model(100000, 0, 1'b0) !== 8'sd127) begin
         n_errors++;
         $display("FAIL model_anchor: got %0d %0d, expected -2 127",
                  model(-300, 0, 1'b0), model(100000, 0, 1'b0));
      end
   endtask

   task automatic test_overflow();
      logic signed [7:0] d0;
      do_clr();
      out_ready = 1'b0;
      for (int k = 1; k <= 6; k++) send(k * 128, 0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (overflow !== 1'b1) begin
         n_errors++;
         $display("FAIL overflow_set: got %0b, expected 1", overflow);
      end
      d0 = out_data;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_data !== 8'sd1 || out_idx !== '0) begin
         n_errors++;
         $display("FAIL full_head: got valid=%0b data=%0d idx=%0d, expected 1 1 0",
                  out_valid, out_data, out_idx);
      end
      drain();
      n_checks++;
      if (overflow !== 1'b1) begin
         n_errors++;
         $display("FAIL overflow_sticky: got %0b, expected 1", overflow);
      end
      send(9 * 128, 0, 1'b0);
      drain();
      do_clr();
      n_checks++;
      if (overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL overflow_clr: got %0b, expected 0", overflow);
      end
   endtask

   task automatic test_layer();
      int vals[10] = '{10, -5, 20, 50, 3, 0, 49, 50, -20, 7};
`ifdef REQUANT_ARGMAX_EN
      int pulses = 0;
      logic [IDX_W-1:0] got_idx = '0;
`endif
      do_clr();
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) send(vals[k] * 128, 0, 1'b0);
      for (int k = 0; k < 6; k++) begin
`ifdef REQUANT_ARGMAX_EN
         if (argmax_valid) begin
            pulses++;
            got_idx = argmax_idx;
         end
`endif
         step();
      end
      drain();
`ifdef REQUANT_ARGMAX_EN
      n_checks++;
      if (pulses != 1 || got_idx !== IDX_W'(3)) begin
         n_errors++;
         $display("FAIL argmax: got pulses=%0d idx=%0d, expected 1 3", pulses, got_idx);
      end
`endif
   endtask

   task automatic test_back_to_back();
      do_clr();
      out_ready = 1'b1;
      for (int k = 0; k < 23; k++) begin
         send(int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 2000)) - 1000,
              1'($urandom_range(0, 1)));
      end
      drain();
   endtask

   task automatic test_clr_inflight();
      int n_seen = 0;
      do_clr();
      out_ready = 1'b1;
      acc_valid = 1'b1;
      acc_data  = 9 * 128;
      bias      = 0;
      relu_en   = 1'b0;
      @(negedge clk);
      clr       = 1'b1;
      acc_data  = 8 * 128;
      @(negedge clk);
      clr       = 1'b0;
      acc_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (out_valid) n_seen++;
         @(negedge clk);
      end
      n_checks++;
      if (n_seen != 0) begin
         n_errors++;
         $display("FAIL clr_discard: got %0d valid cycles, expected 0", n_seen);
      end
      exp_cnt = 0;
      send(3 * 128, 0, 1'b0);
      drain();
   endtask

   task automatic test_reset_midlayer();
      do_clr();
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) send(k * 128, 0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || overflow !== 1'b0 || out_idx !== '0 || out_data !== 8'sd0) begin
         n_errors++;
         $display("FAIL reset_async: got valid=%0b ovf=%0b idx=%0d data=%0d, expected all 0",
                  out_valid, overflow, out_idx, out_data);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      exp_cnt = 0;
      occ = 0;
      out_ready = 1'b1;
      send(11 * 128, 0, 1'b0);
      drain();
      n_checks++;
      if (overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_overflow: got %0b, expected 0", overflow);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      acc_valid = 1'b0;
      acc_data  = '0;
      bias      = '0;
      relu_en   = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_latency();
      test_rounding();
      test_overflow();
      test_layer();
      test_back_to_back();
      test_clr_inflight();
      test_reset_midlayer();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/requant_relu_stage.md
REQUANT_RELU_STAGE -- requirements
Module: requant_relu_stage

Interface
REQ-001 Parameter NUM_NEURONS, 10, dot products per layer; output index wraps after this count.
REQ-002 Parameter SHIFT, 7, requantization right-shift amount, range 1..16.
REQ-003 Parameter FIFO_DEPTH, 4, output buffer entries, power of two.
REQ-004 clk  input  1  the single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 acc_valid  input  1  one-cycle strobe: acc_data and bias valid (driven by the upstream result_valid).
REQ-007 acc_data  input  32 signed  dot-product accumulator.
REQ-008 bias  input  32 signed  bias for the current neuron, sampled with acc_valid.
REQ-009 relu_en  input  1  sampled with acc_valid; 1 = clamp negative results to 0.
REQ-010 clr  input  1  synchronous clear of neuron counter, pipeline, FIFO, overflow, argmax state.
REQ-011 out_ready  input  1  downstream accepts the output word.
REQ-012 out_valid  output  1  FIFO head valid.
REQ-013 out_data  output  8 signed  requantized activation.
REQ-014 out_idx  output  $clog2(NUM_NEURONS)  neuron index of out_data.
REQ-015 out_last  output  1  out_idx == NUM_NEURONS-1.
REQ-016 overflow  output  1  sticky: a result was dropped because the FIFO was full.
REQ-017 argmax_valid, argmax_idx  output  1, $clog2(NUM_NEURONS)  present only with ARGMAX_EN.

Function
REQ-018 Stage 1 SHALL register sum = acc_data + bias at 33-bit signed width; no wrap.
REQ-019 Stage 2 SHALL compute (sum + 2^(SHIFT-1)) >>> SHIFT (arithmetic, round half up), apply ReLU if the sampled relu_en is 1, then saturate to [-128, 127].
REQ-020 Pipeline latency SHALL be 2 cycles from acc_valid to FIFO push; one result per cycle is accepted; there is no input stall.
REQ-021 Neuron counter SHALL tag each pushed result, increment per result, and wrap from NUM_NEURONS-1 to 0.
REQ-022 Push is accepted when FIFO not full, or full with out_valid && out_ready in the same cycle.
REQ-023 A push refused due to full FIFO SHALL drop the word, set overflow, and still advance the neuron counter.
REQ-024 Pop occurs on out_valid && out_ready; out_data/out_idx/out_last SHALL be stable while out_valid && !out_ready.
REQ-025 Empty FIFO: out_valid = 0, out_data/out_idx/out_last hold last values (0 after reset).
REQ-026 clr asserted SHALL win over a simultaneous acc_valid or in-flight stage data; all discarded.
REQ-027 overflow clears only on reset or clr.

Reset
REQ-028 rst_n low SHALL asynchronously clear pipeline valids, counter, FIFO pointers, overflow, argmax state; all outputs 0.
REQ-029 Reset mid-layer SHALL discard partial layer; next acc_valid is neuron 0.

Configuration
REQ-030 Macro REQUANT_ARGMAX_EN defined: track running max of stage-2 outputs (pre-FIFO, independent of out_ready); strict greater-than, ties keep lowest index; dropped words still count.
REQ-031 With REQUANT_ARGMAX_EN: one cycle after neuron NUM_NEURONS-1 leaves stage 2, argmax_valid pulses 1 cycle with argmax_idx; running max reinitialized to -128/index 0.
REQ-032 Without REQUANT_ARGMAX_EN: argmax ports and logic absent; remaining behaviour identical.

Structure
REQ-033 Shared package SHALL hold ACC_W=32, ACT_W=8, ACT_MIN/ACT_MAX constants and the saturate/round function.
REQ-034 Output buffer SHALL be a sub-module sync_fifo (parameterized width/depth, full/empty, same-cycle push+pop).

Verification
REQ-035 acc=1000, bias=24, relu_en=0 -> out_data=8, out_idx=0, out_valid 2 cycles later.
REQ-036 acc=-300, bias=0: relu_en=0 -> -2; relu_en=1 -> 0.
REQ-037 acc=100000 -> 127; acc=-100000, relu_en=0 -> -128.
REQ-038 out_ready=0, 6 back-to-back results -> first 4 buffered, overflow=1, counter at 6; releasing out_ready yields idx 0..3.
REQ-039 10 results, max 50 at idx 3 and idx 7 -> out_last on idx 9; with REQUANT_ARGMAX_EN argmax_idx=3 one pulse.
REQ-040 rst_n low at neuron 5, then acc_valid -> out_idx=0, overflow=0, FIFO empty during reset.
